entropy_packer: RTL
===================

ENTROPY_PACKER -- requirements
Module: entropy_packer

Interface
REQ-001 Parameter NBITS, default 8: width of the raw sample bus; only samples[0] is packed.
REQ-002 Parameter WORD_W, default 32: output word width; legal range 8..64.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in words; power of two, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  collection enable.
REQ-007 samples  in  NBITS  raw entropy samples; also drive the health test.
REQ-008 sample_valid  in  1  samples carry a new value this cycle.
REQ-009 ht_error  in  1  health-test error for the current sample.
REQ-010 ht_total_failure  in  1  health-test total failure.
REQ-011 clear_fail  in  1  single-cycle pulse that releases the latched failure.
REQ-012 rnd_data  out  WORD_W  head-of-FIFO random word.
REQ-013 rnd_valid  out  1  rnd_data holds a valid word.
REQ-014 rnd_ready  in  1  consumer accepts the word.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently buffered.
REQ-016 fail_latched  out  1  sticky failure status.
REQ-017 dropped_cnt  out  16  count of discarded words; saturates at 0xFFFF.

Function
REQ-018 FSM states are IDLE, COLLECT and FAILED: IDLE goes to COLLECT when enable=1, COLLECT goes to IDLE when enable=0, and any state goes to FAILED when ht_total_failure=1.
REQ-019 A sample is accepted only in COLLECT with sample_valid=1; samples[0] is written to bit position bit_cnt of the packing register (LSB first), and bit_cnt then increments.
REQ-020 A taint flag is set in any accepted-sample cycle with ht_error=1, and ht_error is ignored in cycles where no sample is accepted.
REQ-021 Word completion is the accepted sample with bit_cnt=WORD_W-1 (bits from that sample included); on completion, bit_cnt and taint clear in the same cycle.
REQ-022 On completion, the word is pushed if it is untainted (including the final sample's ht_error) and the FIFO is not full; otherwise it is dropped and dropped_cnt increments, saturating at 0xFFFF.
REQ-023 Latency: a word whose last bit is accepted in cycle N shows rnd_valid=1 in cycle N+1 if the FIFO was empty, with no combinational bypass.
REQ-024 A pop occurs when rnd_valid=1 and rnd_ready=1, and the FIFO presents the next word, or deasserts rnd_valid, in the following cycle.
REQ-025 A push and a pop in the same cycle with the FIFO full both succeed, leaving fifo_level unchanged and dropping nothing.
REQ-026 A push and a pop in the same cycle with the FIFO empty are impossible (rnd_valid=0), so only the push occurs.
REQ-027 When enable=0, collection stops, the partial word and taint are held, and the FIFO keeps draining.
REQ-028 Entering FAILED sets fail_latched=1, clears bit_cnt and taint, and flushes the FIFO, so that rnd_valid=0 and fifo_level=0 in the next cycle.
REQ-029 In FAILED, no sample is accepted and rnd_ready is ignored.
REQ-030 FAILED is left, to IDLE, only on clear_fail=1 with ht_total_failure=0, which also clears fail_latched.
REQ-031 If clear_fail=1 and ht_total_failure=1 in the same cycle, failure takes priority and the block stays in FAILED.
REQ-032 rnd_data is stable while rnd_valid=1 and rnd_ready=0.

Reset
REQ-033 Asserting rst at any time immediately places the block in IDLE with bit_cnt=0, taint=0, the FIFO empty, rnd_valid=0, rnd_data=0, fifo_level=0, fail_latched=0 and dropped_cnt=0.
REQ-034 A reset that arrives mid-word discards the partial word without counting it as dropped.

Structure
REQ-035 Package trng_pkg holds the default WORD_W and FIFO_DEPTH constants and the packer state enum (IDLE, COLLECT, FAILED).
REQ-036 The FIFO is a sub-module named trng_sync_fifo, with registered outputs and a synchronous flush input, using the same clk and rst.

Verification
REQ-037 Scenario: enable=1, sample_valid=1 each cycle, samples[0] alternating 1,0 starting with 1, ht_error=0 -> rnd_data=0x55555555 with rnd_valid=1 one cycle after the 32nd sample.
REQ-038 Scenario: ht_error=1 on sample 17 only, with all samples[0]=1 -> first word dropped and dropped_cnt=1, and the second word 0xFFFFFFFF is delivered.
REQ-039 Scenario: rnd_ready=0 while 6 words complete -> fifo_level=4 and dropped_cnt=2; then rnd_ready=1 -> the first 4 words drain in order.
REQ-040 Scenario: ht_total_failure pulsed with fifo_level=3 and a partial word of 10 bits -> next cycle fail_latched=1, rnd_valid=0, fifo_level=0; clear_fail together with ht_total_failure=1 -> still FAILED; clear_fail alone -> IDLE, and the next word needs a full 32 samples.
REQ-041 Scenario: enable dropped after 20 bits, held low 50 cycles, then raised -> the word completes after 12 more samples with the first 20 bits intact.
REQ-042 Scenario: rst asserted mid-word and mid-handshake -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the entropy packer: default geometry, the packer
// state encoding and a saturating counter helper.
package trng_pkg;

  localparam int unsigned WORD_W_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned DROP_W         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FAILED  = 2'd2
  } packer_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock word FIFO with registered head/valid/level/full outputs.
// Ports:
//   clk, rst        clock, async active-high reset
//   flush_i         synchronous empty; wins over push and pop
//   push_i/push_data_i  write request (accepted if not full, or full with pop)
//   pop_i           remove head (ignored when empty)
//   rd_data_o       registered head word (0 when empty)
//   rd_valid_o      head word valid
//   level_o         words buffered
//   full_o          level == DEPTH
module trng_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // Pointer/count update and look-ahead of the next head word so the
  // head output can be registered without adding latency.
  always_comb begin
    do_pop   = 1'b0;
    do_push  = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    data_d   = '0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && (!full_q || do_pop);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
      // The slot being written this cycle becomes head only when nothing
      // older remains in front of it.
      if (cnt_d != '0) begin
        if (do_push && (rd_ptr_d == wr_ptr_q)) data_d = push_data_i;
        else                                   data_d = mem_q[rd_ptr_d];
      end
    end
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == LW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign level_o    = cnt_q;
  assign full_o     = full_q;

endmodule

// File: rtl/entropy_packer.sv
// Packs single-bit entropy samples (samples[0]) LSB-first into WORD_W words,
// discards words touched by a health-test error, buffers good words in a
// FIFO and latches total health-test failure until cleared.
// Ports:
//   clk, rst            clock, async active-high reset
//   enable              collection enable
//   samples, sample_valid  raw samples (bit 0 packed) and their strobe
//   ht_error            health-test error for the current sample
//   ht_total_failure    forces FAILED, flushes state
//   clear_fail          releases FAILED when no total failure is present
//   rnd_data/rnd_valid/rnd_ready  output word handshake
//   fifo_level          words buffered
//   fail_latched        sticky failure status
//   dropped_cnt         saturating count of discarded words
module entropy_packer
  import trng_pkg::*;
#(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NBITS-1:0]              samples,
  input  logic                          sample_valid,
  input  logic                          ht_error,
  input  logic                          ht_total_failure,
  input  logic                          clear_fail,
  output logic [WORD_W-1:0]             rnd_data,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fail_latched,
  output logic [15:0]                   dropped_cnt
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  packer_state_e     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              taint_q, taint_d;
  logic              fail_q, fail_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [WORD_W-1:0] word_c;
  logic              taint_c;
  logic              push_c, pop_c, flush_c;
  logic              fifo_full;
  logic              unused_samples;

  // Only bit 0 carries entropy into the word.
  assign unused_samples = ^samples;

  // Next-state, packing, taint, drop accounting and FIFO control.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pack_d    = pack_q;
    taint_d   = taint_q;
    fail_d    = fail_q;
    drop_d    = drop_q;
    word_c    = pack_q;
    taint_c   = taint_q;
    push_c    = 1'b0;
    flush_c   = 1'b0;
    pop_c     = 1'b0;

    if (ht_total_failure) begin
      state_d   = FAILED;
      fail_d    = 1'b1;
      bit_cnt_d = '0;
      pack_d    = '0;
      taint_d   = 1'b0;
      flush_c   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pop_c = rnd_valid && rnd_ready;
          if (enable) state_d = COLLECT;
        end
        COLLECT: begin
          pop_c = rnd_valid && rnd_ready;
          if (!enable) state_d = IDLE;
          if (enable && sample_valid) begin
            word_c[bit_cnt_q] = samples[0];
            taint_c           = taint_q | ht_error;
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
              bit_cnt_d = '0;
              pack_d    = '0;
              taint_d   = 1'b0;
              // A simultaneous pop frees the slot, so full only blocks
              // the push when nothing is leaving.
              if (!taint_c && (!fifo_full || pop_c)) push_c = 1'b1;
              else                                  drop_d = sat_inc(drop_q);
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              pack_d    = word_c;
              taint_d   = taint_c;
            end
          end
        end
        FAILED: begin
          flush_c = 1'b1;
          if (clear_fail) begin
            state_d = IDLE;
            fail_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      pack_q    <= '0;
      taint_q   <= 1'b0;
      fail_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pack_q    <= pack_d;
      taint_q   <= taint_d;
      fail_q    <= fail_d;
      drop_q    <= drop_d;
    end
  end

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_c),
    .push_i      (push_c),
    .push_data_i (word_c),
    .pop_i       (pop_c),
    .rd_data_o   (rnd_data),
    .rd_valid_o  (rnd_valid),
    .level_o     (fifo_level),
    .full_o      (fifo_full)
  );

  assign fail_latched = fail_q;
  assign dropped_cnt  = drop_q;

endmodule
